// File: rtl/top_sequencer_fsm_if.sv
// Purpose: note-fetch handshake between a note source (ROM/FIFO) and the sequencer.
// Latency: none (wires only).
// Backpressure: source holds note_valid and its payload until it sees note_ready.
// Ports: note_valid/note_length/note_chmask/note_last driven by the source (master),
//        note_ready driven by the sequencer (slave).
interface top_sequencer_fsm_if #(
    parameter int LEN_W    = 24,
    parameter int CHANNELS = 4
);
    logic                note_valid;
    logic                note_ready;
    logic [LEN_W-1:0]    note_length;
    logic [CHANNELS-1:0] note_chmask;
    logic                note_last;

    modport master (
        output note_valid,
        output note_length,
        output note_chmask,
        output note_last,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_length,
        input  note_chmask,
        input  note_last,
        output note_ready
    );
endinterface

// File: rtl/top_sequencer_fsm.sv
// Purpose: N-channel note sequencer (fetch, trigger, play, articulation gap, end-of-song).
// Latency: note accepted in LOAD -> trigger next cycle -> max(len,1) PLAY cycles -> GAP_CYCLES gap.
// Backpressure: note_ready only in LOAD and not paused; pause freezes PLAY/GAP timing.
// Ports: clk, reset_n (async active-low); run/pause/loop level controls; note (slave side of
//        the fetch interface); load_pulse accept strobe; trigger/gate per channel;
//        remaining = PLAY cycles left; state = encoded FSM state; done = song finished.
module top_sequencer_fsm #(
    parameter int LEN_W      = 24,
    parameter int CHANNELS   = 4,
    parameter int GAP_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 pause,
    input  logic                 loop,
    top_sequencer_fsm_if.slave   note,
    output logic                 load_pulse,
    output logic [CHANNELS-1:0]  trigger,
    output logic [CHANNELS-1:0]  gate,
    output logic [LEN_W-1:0]     remaining,
    output logic [2:0]           state,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_LOAD  = 3'b001,
        S_START = 3'b010,
        S_PLAY  = 3'b011,
        S_GAP   = 3'b100,
        S_DONE  = 3'b101
    } state_t;

    // One counter serves both the note length and the gap, so it must hold either.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int CW    = (LEN_W > GAP_W) ? LEN_W : GAP_W;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q;
    logic [CHANNELS-1:0] mask_q;
    logic                last_q;
    logic                accept;
    state_t              eon_state;

    assign note.note_ready = (state_q == S_LOAD) && !pause;
    assign accept          = note.note_valid && note.note_ready;
    assign load_pulse      = accept;

    // Where a finished note (PLAY, or GAP when present) hands over. A dropped run
    // still lets the current note and its gap finish before going idle.
    always_comb begin
        eon_state = S_LOAD;
        if (!run) begin
            eon_state = S_IDLE;
        end else if (last_q && !loop) begin
            eon_state = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                len_q  <= note.note_length;
                mask_q <= note.note_chmask;
                last_q <= note.note_last;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Zero length plays one cycle, same as length one.
                cnt_d   = (len_q == '0) ? '0 : (CW'(len_q) - CNT_ONE);
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt_q == '0) begin
                        if (GAP_CYCLES == 0) begin
                            state_d = eon_state;
                        end else begin
                            cnt_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt_q == '0) begin
                        state_d = eon_state;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state     = state_q;
    assign trigger   = (state_q == S_START) ? mask_q : '0;
    assign gate      = (state_q == S_PLAY) ? mask_q : '0;
    assign remaining = (state_q == S_PLAY) ? cnt_q[LEN_W-1:0] : '0;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_top_sequencer_fsm.sv
module tb_top_sequencer_fsm;

    localparam int LEN_W = 4;
    localparam int CH    = 4;
    localparam int GAP   = 2;

    localparam logic [2:0] ID = 3'd0, LD = 3'd1, ST = 3'd2, PL = 3'd3, GP = 3'd4, DN = 3'd5;

    typedef struct packed {
        logic             run;
        logic             pause;
        logic             loop;
        logic             valid;
        logic [LEN_W-1:0] len;
        logic [CH-1:0]    mask;
        logic             last;
        logic [2:0]       e_state;
        logic             e_ready;
        logic             e_load;
        logic [CH-1:0]    e_trig;
        logic [CH-1:0]    e_gate;
        logic [LEN_W-1:0] e_rem;
        logic             e_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic run, pause, loop;
    logic load_pulse;
    logic [CH-1:0] trigger, gate;
    logic [LEN_W-1:0] remaining;
    logic [2:0] state;
    logic done;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    top_sequencer_fsm_if #(.LEN_W(LEN_W), .CHANNELS(CH)) bus ();

    top_sequencer_fsm #(.LEN_W(LEN_W), .CHANNELS(CH), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .pause      (pause),
        .loop       (loop),
        .note       (bus),
        .load_pulse (load_pulse),
        .trigger    (trigger),
        .gate       (gate),
        .remaining  (remaining),
        .state      (state),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, input logic p, input logic lp, input logic vl,
                     input logic [LEN_W-1:0] ln, input logic [CH-1:0] mk, input logic la,
                     input logic [2:0] es, input logic er, input logic el,
                     input logic [CH-1:0] et, input logic [CH-1:0] eg,
                     input logic [LEN_W-1:0] erm, input logic ed);
        vec_t x;
        x.run = r; x.pause = p; x.loop = lp; x.valid = vl; x.len = ln; x.mask = mk; x.last = la;
        x.e_state = es; x.e_ready = er; x.e_load = el; x.e_trig = et; x.e_gate = eg;
        x.e_rem = erm; x.e_done = ed;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic lp, input logic vl,
                         input logic [LEN_W-1:0] ln, input logic [CH-1:0] mk, input logic la);
        run = r; pause = p; loop = lp;
        bus.note_valid = vl; bus.note_length = ln; bus.note_chmask = mk; bus.note_last = la;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, '0, '0, 0);

        // Normal note: len 3, mask 0101, then stall 5 cycles in LOAD.
        v(1,0,0,1,3,4'h5,0, ID,0,0,4'h0,4'h0,0,0);
        v(1,0,0,1,3,4'h5,0, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'h5,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h5,2,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h5,1,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h5,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        for (int k = 0; k < 5; k++) v(1,0,0,0,0,4'h0,0, LD,1,0,4'h0,4'h0,0,0);
        // len 5 with 4 paused cycles from the 2nd PLAY cycle -> 9 PLAY cycles.
        v(1,0,0,1,5,4'hA,0, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'hA,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,4,0);
        for (int k = 0; k < 4; k++) v(1,1,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,3,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,3,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,2,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,1,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hA,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        // Pause in LOAD blocks the fetch; then len 0.
        v(1,1,0,1,0,4'h1,0, LD,0,0,4'h0,4'h0,0,0);
        v(1,0,0,1,0,4'h1,0, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'h1,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h1,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        // len 1.
        v(1,0,0,1,1,4'h2,0, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'h2,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h2,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        // Max length, last note, no loop -> DONE.
        v(1,0,0,1,15,4'hF,1, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'hF,4'h0,0,0);
        for (int k = 14; k >= 0; k--) v(1,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'hF,LEN_W'(k),0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, DN,0,0,4'h0,4'h0,0,1);
        v(1,0,0,0,0,4'h0,0, DN,0,0,4'h0,4'h0,0,1);
        v(0,0,0,0,0,4'h0,0, DN,0,0,4'h0,4'h0,0,1);
        v(0,0,0,0,0,4'h0,0, ID,0,0,4'h0,4'h0,0,0);
        // Last note with loop -> back to LOAD.
        v(1,0,1,0,0,4'h0,0, ID,0,0,4'h0,4'h0,0,0);
        v(1,0,1,1,1,4'h4,1, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,1,0,0,4'h0,0, ST,0,0,4'h4,4'h0,0,0);
        v(1,0,1,0,0,4'h0,0, PL,0,0,4'h0,4'h4,0,0);
        v(1,0,1,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(1,0,1,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        // run dropped mid-PLAY: note and gap finish, then IDLE.
        v(1,0,0,1,3,4'h3,0, LD,1,1,4'h0,4'h0,0,0);
        v(1,0,0,0,0,4'h0,0, ST,0,0,4'h3,4'h0,0,0);
        v(0,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h3,2,0);
        v(0,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h3,1,0);
        v(0,0,0,0,0,4'h0,0, PL,0,0,4'h0,4'h3,0,0);
        v(0,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(0,0,0,0,0,4'h0,0, GP,0,0,4'h0,4'h0,0,0);
        v(0,0,0,0,0,4'h0,0, ID,0,0,4'h0,4'h0,0,0);
        v(0,0,0,0,0,4'h0,0, ID,0,0,4'h0,4'h0,0,0);

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_state", 32'(state), 32'(ID));
        chk("rst_outs", {trigger, gate, remaining, done, load_pulse, bus.note_ready}, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].run, vecs[i].pause, vecs[i].loop, vecs[i].valid,
                  vecs[i].len, vecs[i].mask, vecs[i].last);
            #1;
            n_vec++;
            if (state !== vecs[i].e_state || bus.note_ready !== vecs[i].e_ready ||
                load_pulse !== vecs[i].e_load || trigger !== vecs[i].e_trig ||
                gate !== vecs[i].e_gate || remaining !== vecs[i].e_rem ||
                done !== vecs[i].e_done) begin
                n_bad++;
                $display("FAIL vec%0d: got st=%0d rdy=%b ld=%b trg=%h gate=%h rem=%0d done=%b, expected st=%0d rdy=%b ld=%b trg=%h gate=%h rem=%0d done=%b",
                         i, state, bus.note_ready, load_pulse, trigger, gate, remaining, done,
                         vecs[i].e_state, vecs[i].e_ready, vecs[i].e_load, vecs[i].e_trig,
                         vecs[i].e_gate, vecs[i].e_rem, vecs[i].e_done);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of PLAY, between clock edges.
        drive(1, 0, 0, 1, 5, 4'hF, 0);
        repeat (4) @(posedge clk);  // IDLE->LOAD->START->PLAY->PLAY
        #1;
        chk("pre_rst_state", 32'(state), 32'(PL));
        chk("pre_rst_rem", 32'(remaining), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'(ID));
        chk("async_gate", 32'(gate), 32'd0);
        chk("async_trig", 32'(trigger), 32'd0);
        chk("async_rem", 32'(remaining), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_state", 32'(state), 32'(LD));
        chk("post_rst_load", 32'(load_pulse), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/top_sequencer_fsm.md
Name: top_sequencer_fsm

Overview:
- Parametrised top-level note sequencer. Generalises the fixed RESET/LOAD/START/PLAY controller to N channels, configurable length width and inter-note articulation gap.
- Adds:
  - a valid/ready fetch handshake to the note source (ROM/FIFO)
  - pause
  - graceful stop
  - end-of-song handling with optional looping
- Sits between the note memory and the per-channel tone generators.

Parameters:
- LEN_W, 24, width of note length field and play counter (cycles at 2^22 Hz)
- CHANNELS, 4, number of voice channels driven
- GAP_CYCLES, 4096, silent cycles inserted after each note (0 = no gap state)

Ports:
- clk  in  1  system clock, 2^22 Hz
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level: sequencing enabled
- pause  in  1  level: freeze playback timing
- loop  in  1  level: restart after last note instead of stopping
- note_valid  in  1  note source has a note available
- note_ready  out  1  sequencer accepts a note this cycle
- note_length  in  LEN_W  note duration in cycles
- note_chmask  in  CHANNELS  channels to trigger for this note
- note_last  in  1  note is final note of song
- load_pulse  out  1  note accepted (note_valid & note_ready)
- trigger  out  CHANNELS  one-cycle per-channel start strobe
- gate  out  CHANNELS  per-channel note-on level
- remaining  out  LEN_W  cycles left in PLAY
- state  out  3  current state
- done  out  1  song finished

Behaviour:
- State encoding: IDLE=000, LOAD=001, START=010, PLAY=011, GAP=100, DONE=101. Unused encodings go to IDLE next cycle.
- Reset (reset_n low, asynchronous, no clock needed):
  - state=IDLE; counter, len_q, mask_q, last_q = 0.
  - All outputs 0 while reset is held.
  - Synchronous operation resumes on the first clk edge after reset_n rises.
- Outputs and handshake:
  - All outputs are decoded from registered state except load_pulse, which is note_valid & note_ready.
  - note_ready = (state==LOAD) & !pause.
- IDLE: run=1 -> LOAD; else stay.
- LOAD:
  - run=0 -> IDLE.
  - On note_valid & note_ready: capture len_q=note_length, mask_q=note_chmask, last_q=note_last; go to START.
  - Otherwise stall in LOAD indefinitely.
- START:
  - Exactly 1 cycle, unaffected by pause.
  - trigger=mask_q.
  - counter <= (len_q==0) ? 0 : len_q-1.
  - Next state PLAY.
- PLAY:
  - gate=mask_q; remaining=counter.
  - If pause: hold counter and state.
  - Else if counter==0: exit via the end-of-note rule (GAP_CYCLES=0), or go to GAP with counter <= GAP_CYCLES-1.
  - Else decrement counter.
  - PLAY lasts exactly max(len_q,1) unpaused cycles. len_q=0 is treated as 1.
- GAP:
  - gate=0; remaining=0.
  - If pause: hold.
  - Else if counter==0: apply the end-of-note rule.
  - Else decrement.
  - Lasts exactly GAP_CYCLES unpaused cycles.
- End-of-note rule, in priority order:
  1. run=0 -> IDLE (graceful stop; the current note always completes).
  2. last_q & !loop -> DONE.
  3. Otherwise -> LOAD.
- DONE: done=1; run=0 -> IDLE; otherwise stay.
- Outside their own states: trigger=0 outside START; gate=0 outside PLAY; remaining=0 outside PLAY.
- Timing: if START is entered at cycle t with no pause:
  - PLAY occupies t+1 .. t+max(len,1).
  - GAP follows for GAP_CYCLES cycles.
  - LOAD is entered at t+max(len,1)+GAP_CYCLES+1.
  - Back-to-back note period = 2 + max(len,1) + GAP_CYCLES.
- Counter width: max(LEN_W, clog2(GAP_CYCLES+1)). Counter never wraps; decrement occurs only when nonzero.

Test Plan:
1. GAP_CYCLES=2; run=1; note_valid=1 with len=3, mask=0101, last=0 -> state sequence IDLE,LOAD,START,PLAY,PLAY,PLAY,GAP,GAP,LOAD; trigger=0101 for 1 cycle; gate=0101 for 3 cycles; remaining 2,1,0; load_pulse 1 cycle.
2. Hold note_valid=0 for 5 cycles in LOAD -> state stays 001, note_ready=1, no trigger/gate; capture occurs on the first valid cycle.
3. len=5; pause=1 for 4 cycles starting at the 2nd PLAY cycle -> PLAY lasts 9 cycles; remaining frozen at 3 during pause; note_ready=0 if pause is asserted in LOAD.
4. len=0 and len=1 -> each gives exactly 1 PLAY cycle with remaining=0; len=2^LEN_W-1 counts down without wrap.
5. last=1 with loop=0 -> DONE, done=1 held; run dropped -> IDLE next cycle. Same note with loop=1 -> LOAD after GAP.
6. reset_n low mid-PLAY between clock edges -> state, gate, trigger, remaining = 0 immediately. run dropped mid-PLAY -> note finishes, GAP completes, then IDLE, not LOAD.
